// File: rtl/register_access_controller.sv
// register_access_controller: arbitrated register-bank writeback with a 32-entry busy scoreboard gating operand reads.
// Define RAC_FIXED_PRIORITY_EN to give the M source fixed priority instead of round-robin arbitration.
module register_access_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_valid,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   output logic        a_ready,
   input  logic        m_valid,
   input  logic [4:0]  m_addr,
   input  logic [31:0] m_data,
   output logic        m_ready,
   input  logic        rsv_valid,
   input  logic [4:0]  rsv_addr,
   input  logic        rd_req,
   input  logic [4:0]  rd_rs,
   input  logic [4:0]  rd_rt,
   output logic        rd_grant,
   output logic        write_reg,
   output logic [4:0]  RD,
   output logic [31:0] write_data,
   output logic        read_reg,
   output logic [4:0]  RS,
   output logic [4:0]  RT,
   output logic [5:0]  busy_count,
   output logic        err_unreserved
);
   logic        gnt_m, acc, wr_en;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [31:0] busy_q, busy_d, set_m, clr_m;
   logic        write_reg_q, read_reg_q, err_q;
   logic [4:0]  rd_q, rs_q, rt_q;
   logic [31:0] write_data_q;
   logic [5:0]  cnt;

`ifdef RAC_FIXED_PRIORITY_EN
   assign gnt_m = m_valid;
`else
   logic ptr_q;
   // ptr_q high means M wins the next conflict
   assign gnt_m = m_valid & (~a_valid | ptr_q);
   always_ff @(posedge clk)
      if (reset) ptr_q <= 1'b1;
      else if (acc) ptr_q <= ~m_ready;
`endif

   assign m_ready  = ~reset & gnt_m;
   assign a_ready  = ~reset & a_valid & ~gnt_m;
   assign acc      = a_ready | m_ready;
   assign waddr    = m_ready ? m_addr : a_addr;
   assign wdata    = m_ready ? m_data : a_data;
   assign wr_en    = acc & (|waddr);
   assign rd_grant = ~reset & rd_req & ~busy_q[rd_rs] & ~busy_q[rd_rt];

   // reserve is applied after clear so a same-cycle reserve wins
   assign set_m  = (rsv_valid && rsv_addr != 5'd0) ? (32'd1 << rsv_addr) : 32'd0;
   assign clr_m  = wr_en ? (32'd1 << waddr) : 32'd0;
   assign busy_d = (busy_q & ~clr_m) | set_m;

   always_ff @(posedge clk)
      if (reset) begin
         busy_q       <= '0;
         err_q        <= 1'b0;
         write_reg_q  <= 1'b0;
         rd_q         <= '0;
         write_data_q <= '0;
         read_reg_q   <= 1'b0;
         rs_q         <= '0;
         rt_q         <= '0;
      end else begin
         busy_q      <= busy_d;
         err_q       <= err_q | (wr_en & ~busy_q[waddr]);
         write_reg_q <= wr_en;
         read_reg_q  <= rd_grant;
         if (acc) begin
            rd_q         <= waddr;
            write_data_q <= wdata;
         end
         if (rd_grant) begin
            rs_q <= rd_rs;
            rt_q <= rd_rt;
         end
      end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < 32; i++) cnt = cnt + 6'(busy_q[i]);
   end

   assign busy_count     = cnt;
   assign err_unreserved = err_q;
   assign write_reg      = write_reg_q;
   assign RD             = rd_q;
   assign write_data     = write_data_q;
   assign read_reg       = read_reg_q;
   assign RS             = rs_q;
   assign RT             = rt_q;
endmodule

// File: tb/tb_register_access_controller.sv
// tb_register_access_controller: directed vectors with hand-computed expectations for register_access_controller.
module tb_register_access_controller;
   logic        clk = 1'b0, reset = 1'b1;
   logic        a_valid = 0, m_valid = 0, rsv_valid = 0, rd_req = 0;
   logic [4:0]  a_addr = 0, m_addr = 0, rsv_addr = 0, rd_rs = 0, rd_rt = 0;
   logic [31:0] a_data = 0, m_data = 0;
   logic        a_ready, m_ready, rd_grant, write_reg, read_reg, err_unreserved;
   logic [4:0]  RD, RS, RT;
   logic [31:0] write_data;
   logic [5:0]  busy_count;
   int          n_chk = 0, n_err = 0;
   logic [3:0]  exp_m;

   register_access_controller dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
      .rd_req(rd_req), .rd_rs(rd_rs), .rd_rt(rd_rt), .rd_grant(rd_grant),
      .write_reg(write_reg), .RD(RD), .write_data(write_data),
      .read_reg(read_reg), .RS(RS), .RT(RT),
      .busy_count(busy_count), .err_unreserved(err_unreserved)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      // reset: all outputs idle and requests refused
      a_valid = 1; m_valid = 1; rd_req = 1;
      step();
      check("rst_a_ready", a_ready, 0);
      check("rst_m_ready", m_ready, 0);
      check("rst_rd_grant", rd_grant, 0);
      step();
      check("rst_busy", busy_count, 0);
      check("rst_wr", write_reg, 0);
      check("rst_err", err_unreserved, 0);
      check("rst_rd", RD, 0);
      a_valid = 0; m_valid = 0; rd_req = 0;
      reset = 0;

      // reserve 5 and 7, then reads gated by busy
      rsv_valid = 1; rsv_addr = 5; step();
      rsv_addr = 7; step();
      rsv_valid = 0;
      check("busy_2", busy_count, 2);
      rd_req = 1; rd_rs = 5; rd_rt = 7; #1;
      check("rd_blocked", rd_grant, 0);
      rd_rs = 1; rd_rt = 2; #1;
      check("rd_free", rd_grant, 1);
      step();
      rd_req = 0;
      check("read_reg", read_reg, 1);
      check("rs", RS, 1);
      check("rt", RT, 2);
      step();
      check("read_reg_off", read_reg, 0);

      // single A write commits and clears busy[5]
      a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF; #1;
      check("a_ready", a_ready, 1);
      check("m_ready_idle", m_ready, 0);
      step();
      a_valid = 0;
      check("a_wr", write_reg, 1);
      check("a_rd", RD, 5);
      check("a_data", write_data, 32'hDEADBEEF);
      check("a_busy", busy_count, 1);
      check("a_err", err_unreserved, 0);
      step();
      check("wr_pulse", write_reg, 0);
      check("data_hold", write_data, 32'hDEADBEEF);
      rd_req = 1; rd_rs = 7; rd_rt = 0; #1;
      check("rd_7_busy", rd_grant, 0);
      rd_req = 0;

      // arbitration under sustained conflict
      do_reset();
      rsv_valid = 1; rsv_addr = 3; step();
      rsv_addr = 4; step();
      rsv_valid = 0;
`ifdef RAC_FIXED_PRIORITY_EN
      exp_m = 4'b1111;
`else
      exp_m = 4'b0101;
`endif
      a_valid = 1; a_addr = 3; a_data = 32'hA;
      m_valid = 1; m_addr = 4; m_data = 32'hB;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("arb_m%0d", i), m_ready, exp_m[i]);
         check($sformatf("arb_a%0d", i), a_ready, !exp_m[i]);
         step();
         check($sformatf("arb_d%0d", i), write_data, exp_m[i] ? 32'hB : 32'hA);
      end
      a_valid = 0; m_valid = 0;

      // reserve and commit of 9 in the same cycle: reserve wins
      do_reset();
      rsv_valid = 1; rsv_addr = 9; step();
      m_valid = 1; m_addr = 9; m_data = 32'h99; step();
      m_valid = 0; rsv_valid = 0;
      check("rc_wr", write_reg, 1);
      check("rc_busy", busy_count, 1);
      check("rc_err", err_unreserved, 0);
      rd_req = 1; rd_rs = 9; rd_rt = 0; #1;
      check("rc_rd_blocked", rd_grant, 0);
      rd_req = 0;
      rsv_valid = 1; rsv_addr = 9; step();
      rsv_valid = 0;
      check("rerserve_cnt", busy_count, 1);

      // writes to r0 and to an unreserved register
      m_valid = 1; m_addr = 0; m_data = 32'h1; #1;
      check("r0_ready", m_ready, 1);
      step();
      m_valid = 0;
      check("r0_wr", write_reg, 0);
      check("r0_err", err_unreserved, 0);
      check("r0_busy", busy_count, 1);
      m_valid = 1; m_addr = 12; m_data = 32'h2; step();
      m_valid = 0;
      check("unr_wr", write_reg, 1);
      check("unr_rd", RD, 12);
      check("unr_err", err_unreserved, 1);
      step(); step();
      check("err_sticky", err_unreserved, 1);

      // reset right after an accepted write discards it
      a_valid = 1; a_addr = 9; a_data = 32'h3; step();
      check("pre_rst_wr", write_reg, 1);
      reset = 1; m_valid = 1; m_addr = 9; rd_req = 1; rd_rs = 0; rd_rt = 0; #1;
      check("rst2_a_ready", a_ready, 0);
      check("rst2_m_ready", m_ready, 0);
      check("rst2_rd_grant", rd_grant, 0);
      step();
      check("rst2_wr", write_reg, 0);
      check("rst2_busy", busy_count, 0);
      check("rst2_err", err_unreserved, 0);
      reset = 0; a_valid = 0; m_valid = 0; rd_req = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
